// File: rtl/idma_sync_256b_wr_sched.sv
// idma_sync_256b_wr_sched: splits a write descriptor into 4 KB-safe AXI INCR bursts with B-response credit limiting
module idma_sync_256b_wr_sched #(
   parameter int AXI_IDW         = 4,
   parameter int ADDR_W          = 32,
   parameter int LEN_W           = 20,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic               cfg_start,
   input  logic [ADDR_W-1:0]  cfg_addr,
   input  logic [LEN_W-1:0]   cfg_len,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err,
   output logic               wr_cfg_init,
   output logic               o_awvalid,
   input  logic               i_awready,
   output logic [ADDR_W-1:0]  o_awaddr,
   output logic [3:0]         o_awlen,
   output logic [2:0]         o_awsize,
   output logic [1:0]         o_awburst,
   output logic [AXI_IDW-1:0] o_awid,
   input  logic               wlen_fifo_full_s,
   output logic               wlen_fifo_push,
   output logic [3:0]         wlen_fifo_data_s,
   output logic               axi_burst_waddr_ok,
   input  logic               i_bvalid,
   input  logic [1:0]         i_bresp,
   output logic [5:0]         strb_first_beat_num,
   output logic [5:0]         strb_last_beat_num,
   output logic               dma_trans_first_burst,
   output logic               dma_trans_last_burst
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   typedef enum logic [1:0] {IDLE, CALC, AW, WAIT_B} state_e;
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_nx;
   logic [LEN_W-1:0]  rem_q, rem_d, rem_nx, cons;
   logic [3:0]        awlen_q, awlen_d;
   logic [CW-1:0]     out_q, out_d;
   logic              awvalid_q, awvalid_d, err_q, err_d, done_q, done_d;
   logic              init_q, init_d, busy_q, busy_d;
   logic              first_pend_q, first_pend_d, first_q, first_d, last_q, last_d;
   logic [5:0]        sfirst_q, sfirst_d, slast_q, slast_d;
   logic              accept, hs, bdec, can_issue;
   logic [LEN_W:0]    span, nbeats;
   logic [4:0]        min16, bcalc, beats, lsum;
   logic [7:0]        to4k;
   logic [9:0]        cap;
   assign accept    = state_q == IDLE && !busy_q && cfg_start;
   assign hs        = awvalid_q && i_awready;
   // B responses with nothing outstanding (e.g. after a mid-transfer reset) are dropped
   assign bdec      = i_bvalid && out_q != '0;
   assign can_issue = (out_q - CW'(bdec)) < CW'(MAX_OUTSTANDING) && !wlen_fifo_full_s;
   assign span      = (LEN_W+1)'(rem_q) + (LEN_W+1)'(addr_q[4:0]) + (LEN_W+1)'(31);
   assign nbeats    = span >> 5;
   assign min16     = (nbeats > (LEN_W+1)'(16)) ? 5'd16 : nbeats[4:0];
   assign to4k      = 8'd128 - 8'(addr_q[11:5]);
   assign bcalc     = (to4k < 8'(min16)) ? to4k[4:0] : min16;
   assign beats     = {1'b0, awlen_q} + 5'd1;
   assign cap       = {beats, 5'b0} - 10'(addr_q[4:0]);
   assign cons      = (rem_q < LEN_W'(cap)) ? rem_q : LEN_W'(cap);
   assign rem_nx    = rem_q - cons;
   assign addr_nx   = {addr_q[ADDR_W-1:5] + (ADDR_W-5)'(beats), 5'b0};
   assign lsum      = cfg_addr[4:0] + cfg_len[4:0] - 5'd1;
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      awlen_d      = awlen_q;
      awvalid_d    = awvalid_q;
      done_d       = 1'b0;
      init_d       = 1'b0;
      first_pend_d = first_pend_q;
      first_d      = first_q;
      last_d       = last_q;
      sfirst_d     = sfirst_q;
      slast_d      = slast_q;
      err_d        = err_q | (bdec && i_bresp != 2'b00);
      out_d        = out_q + CW'(hs) - CW'(bdec);
      case (state_q)
         IDLE: if (accept) begin
            if (cfg_len != '0) begin
               state_d      = CALC;
               addr_d       = cfg_addr;
               rem_d        = cfg_len;
               init_d       = 1'b1;
               err_d        = 1'b0;
               first_pend_d = 1'b1;
               sfirst_d     = {1'b0, cfg_addr[4:0]};
               slast_d      = {1'b0, lsum} + 6'd1;
            end else begin
               done_d = 1'b1;
            end
         end
         CALC: begin
            awlen_d   = 4'(bcalc - 5'd1);
            awvalid_d = can_issue;
            state_d   = AW;
         end
         AW: if (hs) begin
            awvalid_d    = 1'b0;
            rem_d        = rem_nx;
            addr_d       = addr_nx;
            first_d      = first_pend_q;
            last_d       = rem_nx == '0;
            first_pend_d = 1'b0;
            state_d      = (rem_nx == '0) ? WAIT_B : CALC;
         end else if (!awvalid_q) begin
            awvalid_d = can_issue;
         end
         WAIT_B: if (out_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
      endcase
      busy_d = state_d != IDLE || state_q == WAIT_B;
   end
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         rem_q        <= '0;
         awlen_q      <= '0;
         out_q        <= '0;
         awvalid_q    <= 1'b0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
         init_q       <= 1'b0;
         busy_q       <= 1'b0;
         first_pend_q <= 1'b0;
         first_q      <= 1'b0;
         last_q       <= 1'b0;
         sfirst_q     <= '0;
         slast_q      <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rem_q        <= rem_d;
         awlen_q      <= awlen_d;
         out_q        <= out_d;
         awvalid_q    <= awvalid_d;
         err_q        <= err_d;
         done_q       <= done_d;
         init_q       <= init_d;
         busy_q       <= busy_d;
         first_pend_q <= first_pend_d;
         first_q      <= first_d;
         last_q       <= last_d;
         sfirst_q     <= sfirst_d;
         slast_q      <= slast_d;
      end
   end
   assign o_busy                = busy_q;
   assign o_done                = done_q;
   assign o_err                 = err_q;
   assign wr_cfg_init           = init_q;
   assign o_awvalid             = awvalid_q;
   assign o_awaddr              = {addr_q[ADDR_W-1:5], 5'b0};
   assign o_awlen               = awlen_q;
   assign o_awsize              = 3'd5;
   assign o_awburst             = 2'b01;
   assign o_awid                = '0;
   assign wlen_fifo_push        = hs;
   assign wlen_fifo_data_s      = awlen_q;
   assign axi_burst_waddr_ok    = hs;
   assign strb_first_beat_num   = sfirst_q;
   assign strb_last_beat_num    = slast_q;
   assign dma_trans_first_burst = first_q;
   assign dma_trans_last_burst  = last_q;
endmodule
